// File: rtl/direction_queue.sv
// Direction register with a small turn FIFO: filters key presses into legal turns,
// queues them, and commits one queued turn per game-step tick.
module direction_queue #(
    parameter int          DEPTH         = 2,
    parameter logic [1:0]  INIT_DIR      = 2'b01,
    parameter bit          ALLOW_REVERSE = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       left,
    input  logic                       up,
    input  logic                       right,
    input  logic                       down,
    input  logic                       tick,
    output logic [1:0]                 dir,
    output logic                       dir_changed,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        D_UP    = 2'b00,
        D_RIGHT = 2'b01,
        D_DOWN  = 2'b10,
        D_LEFT  = 2'b11
    } dir_t;

    logic [3:0]    keys;
    logic [3:0]    prev;
    logic [3:0]    edges;
    logic          cand_valid;
    logic [1:0]    cand;
    logic [1:0]    tail;
    logic          accept;
    logic          room;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] last_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign keys  = {left, up, right, down};
    assign edges = keys & ~prev;

    // Only a single fresh edge is a press; chords are ignored outright.
    always_comb begin
        cand_valid = 1'b1;
        cand       = D_UP;
        unique case (edges)
            4'b1000: cand = D_LEFT;
            4'b0100: cand = D_UP;
            4'b0010: cand = D_RIGHT;
            4'b0001: cand = D_DOWN;
            default: cand_valid = 1'b0;
        endcase
    end

    assign last_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
    assign tail     = (count != '0) ? mem[last_ptr] : dir;

    always_comb begin
        accept = cand_valid && (cand != tail);
        if (!ALLOW_REVERSE && (cand == (tail ^ 2'b10)))
            accept = 1'b0;
    end

    // A pop in the same cycle frees the slot a full-queue push needs.
    assign do_pop  = tick && (count != '0);
    assign room    = (count < CW'(DEPTH)) || do_pop;
    assign do_push = accept && room;
    assign drop    = accept && !room;

    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wr_ptr] <= cand;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dir         <= INIT_DIR;
            dir_changed <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prev        <= keys;
            dir_changed <= do_pop;
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                dir    <= mem[rd_ptr];
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    assign pending = count;

endmodule
